audio_frame_gen: RTL

//  Upstream feeder of the I2S serializer on the speaker path.
//  - Divides the system clock into the codec clocks mclk, sck and lrck.
//  - Generates one square-wave tone per channel from note_div_l / note_div_r and volume.
//  - Holds audio_left/audio_right stable for one full lrck frame, so the serializer
//    (shifting on sck negedge) never sees a sample change mid-frame.

---
 rtl/audio_frame_gen.sv | 95 +++++++++
 1 files changed

// File: rtl/audio_frame_gen.sv
// audio_frame_gen
//   Front end of the speaker-path I2S serializer. Divides clk into the codec
//   clocks, runs one square-wave tone generator per channel and latches one
//   signed sample per channel at the end of every lrck frame, so the samples
//   never change while the serializer is shifting a frame out.
//
// Ports
//   clk, rst                  system clock, async active-high reset
//   note_div_l, note_div_r    tone half-period in clk cycles, 0 = silence
//   volume                    amplitude level 0..7
//   mute                      forces both latched samples to 0
//   mclk, sck, lrck           clk/4, clk/16, clk/512 (bits of frame_cnt)
//   audio_left, audio_right   signed samples, held for a full frame
//   sample_strobe             high during the clk whose closing edge loads samples
module audio_frame_gen #(
  parameter int NOTE_W = 22,
  parameter int VOL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note_div_l,
  input  logic [NOTE_W-1:0] note_div_r,
  input  logic [VOL_W-1:0]  volume,
  input  logic              mute,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic [15:0]       audio_left,
  output logic [15:0]       audio_right,
  output logic              sample_strobe
);

  localparam int NCH = 2;

  logic [8:0]                  frame_cnt;
  logic [NCH-1:0][NOTE_W-1:0]  note_div;
  logic [NCH-1:0]              phase;
  logic [NCH-1:0][15:0]        sample_nxt;
  logic [15:0]                 amp;

  assign note_div = {note_div_r, note_div_l};

  // Volume lands in bits [14:12]; the sign bit stays clear so -amp never overflows.
  assign amp = 16'({volume, 12'h000});

  // Codec clocks are straight taps of the registered frame counter.
  assign mclk = frame_cnt[1];
  assign sck  = frame_cnt[3];
  assign lrck = frame_cnt[8];

  // Per-channel tone generator: half-period counter plus phase flag.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [NOTE_W-1:0] cnt;
    logic              ph;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        ph  <= 1'b0;
      end else if (note_div[g] == '0) begin
        cnt <= '0;
        ph  <= 1'b0;
      end else if (cnt >= note_div[g] - NOTE_W'(1)) begin
        // >= rather than ==: shrinking note_div below cnt wraps at once.
        cnt <= '0;
        ph  <= ~ph;
      end else begin
        cnt <= cnt + NOTE_W'(1);
      end
    end

    assign phase[g] = ph;
    assign sample_nxt[g] = (mute || note_div[g] == '0) ? 16'h0000 :
                           (ph ? amp : 16'(-amp));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt     <= '0;
      sample_strobe <= 1'b0;
      audio_left    <= '0;
      audio_right   <= '0;
    end else begin
      frame_cnt     <= frame_cnt + 9'd1;
      // Registered one clk early so the strobe covers the frame_cnt==511 clk.
      sample_strobe <= (frame_cnt == 9'd510);
      if (frame_cnt == 9'd511) begin
        // Current (pre-toggle) phase is what gets latched.
        audio_left  <= sample_nxt[0];
        audio_right <= sample_nxt[1];
      end
    end
  end

endmodule
